box_anim_ctrl: RTL and testbench

- Animation sequencer for the box-drawing engine (go/erase/done handshake, 160x120 VGA, 6-bit colour).
- Repeatedly draws a box, waits a programmable number of frame ticks, erases it, steps its position one pixel diagonally, and redraws.
- Bounces off the screen edges.
- Sits between the top-level frame-tick source and the box drawer; owns position, direction and request sequencing.

---
 rtl/box_anim_pkg.sv | 27 ++
 rtl/bounce_axis.sv | 46 ++++
 rtl/box_anim_ctrl.sv | 122 ++++++++++++
 tb/tb_box_anim_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/box_anim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : box_anim_pkg
// Brief    : Shared screen constants, coordinate widths and sequencer states.
// Revision : 1.0
// ============================================================================
package box_anim_pkg;

    localparam int X_SCREEN_PIXELS = 160;
    localparam int Y_SCREEN_PIXELS = 120;
    localparam int X_W             = 8;
    localparam int Y_W             = 7;
    localparam int COL_W           = 6;
    localparam int CNT_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAW_REQ   = 3'd1,
        ST_DRAW_WAIT  = 3'd2,
        ST_HOLD       = 3'd3,
        ST_ERASE_REQ  = 3'd4,
        ST_ERASE_WAIT = 3'd5,
        ST_MOVE       = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bounce_axis.sv
`default_nettype none
// ============================================================================
// Module   : bounce_axis
// Brief    : One-axis position/direction register that reflects off 0 and MAX.
// Revision : 1.0
// ============================================================================
module bounce_axis
    import box_anim_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = 156,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [WIDTH-1:0] pos,
    output logic             dir_neg
);

    localparam logic [WIDTH-1:0] POS_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] POS_INIT = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // Reaching an edge flips direction and moves back one pixel in the same step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= POS_INIT;
            dir_neg <= 1'b0;
        end else if (step) begin
            if (!dir_neg && pos == POS_MAX) begin
                dir_neg <= 1'b1;
                pos     <= pos - ONE;
            end else if (dir_neg && pos == '0) begin
                dir_neg <= 1'b0;
                pos     <= pos + ONE;
            end else if (dir_neg) begin
                pos     <= pos - ONE;
            end else begin
                pos     <= pos + ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/box_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : box_anim_ctrl
// Brief    : Draw / hold / erase / move sequencer driving the box drawer.
// Revision : 1.0
// ============================================================================
module box_anim_ctrl
    import box_anim_pkg::*;
#(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int BOX_W           = 4,
    parameter int BOX_H           = 4,
    parameter int X0              = 0,
    parameter int Y0              = 0,
    parameter int FRAMES_PER_STEP = 15
) (
    input  logic             iClock,
    input  logic             iResetn,
    input  logic             iEnable,
    input  logic             iFrameTick,
    input  logic [COL_W-1:0] iColour,
    input  logic             iDone,
    output logic             oGo,
    output logic             oErase,
    output logic [X_W-1:0]   oX,
    output logic [Y_W-1:0]   oY,
    output logic [COL_W-1:0] oColour,
    output logic [7:0]       oXDim,
    output logic [7:0]       oYDim,
    output logic             oBusy
);

    localparam logic [CNT_W-1:0] STEP_FRAMES = CNT_W'(FRAMES_PER_STEP);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   frame_cnt;
    logic               count_tick;
    logic               hold_expired;
    logic               step_pos;

    assign count_tick   = (state == ST_HOLD) && iEnable && iFrameTick;
    assign hold_expired = count_tick && ((frame_cnt + CNT_W'(1)) == STEP_FRAMES);
    assign step_pos     = (state == ST_MOVE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (iEnable) next_state = ST_DRAW_REQ;
            ST_DRAW_REQ:   next_state = ST_DRAW_WAIT;
            ST_DRAW_WAIT:  if (iDone) next_state = ST_HOLD;
            ST_HOLD:       if (hold_expired) next_state = ST_ERASE_REQ;
            ST_ERASE_REQ:  next_state = ST_ERASE_WAIT;
            ST_ERASE_WAIT: if (iDone) next_state = ST_MOVE;
            ST_MOVE:       next_state = iEnable ? ST_DRAW_REQ : ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request fields change only on entry to a REQ state, so they stay put until iDone.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oGo       <= 1'b0;
            oErase    <= 1'b0;
            oColour   <= '0;
            frame_cnt <= '0;
        end else begin
            oGo <= (next_state == ST_DRAW_REQ) || (next_state == ST_ERASE_REQ);
            if (next_state == ST_DRAW_REQ) begin
                oErase  <= 1'b0;
                oColour <= iColour;
            end else if (next_state == ST_ERASE_REQ) begin
                oErase  <= 1'b1;
            end
            if (state == ST_DRAW_WAIT && iDone) begin
                frame_cnt <= '0;
            end else if (count_tick) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    assign oBusy = (state == ST_DRAW_REQ)  || (state == ST_DRAW_WAIT) ||
                   (state == ST_ERASE_REQ) || (state == ST_ERASE_WAIT);
    assign oXDim = 8'(BOX_W);
    assign oYDim = 8'(BOX_H);

    bounce_axis #(
        .WIDTH (X_W),
        .MAX   (X_SCREEN_PIXELS - BOX_W),
        .INIT  (X0)
    ) u_axis_x (
        .clk     (iClock),
        .rst_n   (iResetn),
        .step    (step_pos),
        .pos     (oX),
        .dir_neg ()
    );

    bounce_axis #(
        .WIDTH (Y_W),
        .MAX   (Y_SCREEN_PIXELS - BOX_H),
        .INIT  (Y0)
    ) u_axis_y (
        .clk     (iClock),
        .rst_n   (iResetn),
        .step    (step_pos),
        .pos     (oY),
        .dir_neg ()
    );

endmodule
`default_nettype wire

// File: tb/tb_box_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_box_anim_ctrl
// Brief    : Randomised request-level scoreboard for box_anim_ctrl (two placements).
// Revision : 1.0
// ============================================================================
module tb_box_anim_ctrl;

    localparam int XMAX  = 156;
    localparam int YMAX  = 116;
    localparam int FPS   = 15;
    localparam int STEPS = 400;

    localparam int P_ARM   = 0;
    localparam int P_DREQ  = 1;
    localparam int P_DWAIT = 2;
    localparam int P_HOLD  = 3;
    localparam int P_EREQ  = 4;
    localparam int P_EWAIT = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       tick  = 1'b0;
    logic       done  = 1'b0;
    logic [5:0] col   = '0;

    logic       go, erase, busy;
    logic [7:0] x, xdim, ydim;
    logic [6:0] y;
    logic [5:0] colour;

    logic       b_go, b_erase, b_busy;
    logic [7:0] b_x, b_xdim, b_ydim;
    logic [6:0] b_y;
    logic [5:0] b_colour;

    box_anim_ctrl dut (
        .iClock(clk), .iResetn(rst_n), .iEnable(en), .iFrameTick(tick),
        .iColour(col), .iDone(done), .oGo(go), .oErase(erase), .oX(x), .oY(y),
        .oColour(colour), .oXDim(xdim), .oYDim(ydim), .oBusy(busy)
    );

    box_anim_ctrl #(.X0(156), .Y0(116)) dut_corner (
        .iClock(clk), .iResetn(rst_n), .iEnable(en), .iFrameTick(tick),
        .iColour(col), .iDone(done), .oGo(b_go), .oErase(b_erase), .oX(b_x), .oY(b_y),
        .oColour(b_colour), .oXDim(b_xdim), .oYDim(b_ydim), .oBusy(b_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Diagonal motion with edge reflection is a triangle wave of the step count.
    function automatic int tri_pos(input int p0, input int mx, input int n);
        int t;
        t = (p0 + n) % (2 * mx);
        return (t <= mx) ? t : 2 * mx - t;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_go"}, go, 0);
        chk({tag, "_erase"}, erase, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_colour"}, colour, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_bx"}, b_x, 156);
        chk({tag, "_by"}, b_y, 116);
        chk({tag, "_bgo"}, b_go, 0);
        chk({tag, "_bbusy"}, b_busy, 0);
    endtask

    int phase = P_ARM;
    int cnt = 0;
    int n = 0;
    int steps = 0;
    int cd = 0;
    int cycle = 0;
    bit exp_go = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_er = 1'b0;
    int exp_col = 0;
    bit did_reset = 1'b0;
    bit drv_done, spurious;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_reset("reset");
        chk("xdim", xdim, 4);
        chk("ydim", ydim, 4);
        chk("b_xdim", b_xdim, 4);
        chk("b_ydim", b_ydim, 4);
        chk("b_erase", b_erase, 0);
        chk("b_colour", b_colour, 0);
        @(negedge clk);
        rst_n = 1'b1;

        while (steps < STEPS && cycle < 60000) begin
            @(negedge clk);
            cycle++;

            if (!did_reset && steps == 150 && phase == P_EWAIT) begin
                #2;
                rst_n = 1'b0;
                en    = 1'b0;
                tick  = 1'b0;
                done  = 1'b0;
                #1;
                chk_reset("async_reset");
                @(negedge clk);
                rst_n     = 1'b1;
                n         = 0;
                cd        = 0;
                phase     = P_ARM;
                exp_go    = 1'b0;
                exp_busy  = 1'b0;
                did_reset = 1'b1;
                continue;
            end

            chk("go", go, exp_go);
            chk("b_go", b_go, exp_go);
            chk("busy", busy, exp_busy);
            if (exp_busy) begin
                chk("req_erase", erase, exp_er);
                chk("req_x", x, tri_pos(0, XMAX, n));
                chk("req_y", y, tri_pos(0, YMAX, n));
                chk("req_colour", colour, exp_col);
                chk("corner_x", b_x, tri_pos(156, XMAX, n));
                chk("corner_y", b_y, tri_pos(116, YMAX, n));
            end
            if (go) begin
                chk("x_in_range", (x <= XMAX), 1);
                chk("y_in_range", (y <= YMAX), 1);
                cd = (steps < 3) ? 6 : $urandom_range(2, 7);
            end

            en       = ($urandom_range(0, 99) < 85);
            tick     = $urandom_range(0, 1) == 1;
            col      = 6'($urandom);
            drv_done = 1'b0;
            if (cd > 0) begin
                cd--;
                drv_done = (cd == 0);
            end
            spurious = (phase != P_DWAIT) && (phase != P_EWAIT) && ($urandom_range(0, 9) == 0);
            done     = drv_done | spurious;

            exp_go = 1'b0;
            case (phase)
                P_ARM: if (en) begin
                    exp_go  = 1'b1;
                    exp_er  = 1'b0;
                    exp_col = int'(col);
                    phase   = P_DREQ;
                end
                P_DREQ:  phase = P_DWAIT;
                P_DWAIT: if (done) begin
                    phase = P_HOLD;
                    cnt   = 0;
                end
                P_HOLD: if (en && tick) begin
                    cnt++;
                    if (cnt == FPS) begin
                        exp_go = 1'b1;
                        exp_er = 1'b1;
                        phase  = P_EREQ;
                    end
                end
                P_EREQ:  phase = P_EWAIT;
                P_EWAIT: if (done) begin
                    n++;
                    steps++;
                    phase = P_ARM;
                end
                default: phase = P_ARM;
            endcase
            exp_busy = (phase == P_DREQ) || (phase == P_DWAIT) ||
                       (phase == P_EREQ) || (phase == P_EWAIT);
        end

        chk("steps_completed", (steps >= STEPS), 1);
        chk("reset_exercised", did_reset, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
